// File: rtl/enet_tx_arbiter_if.sv
// Bundle between packet sources / DM9000A driver and the transmit arbiter.
// The master side is the sources plus driver; the slave side is the arbiter.
interface enet_tx_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_WORDS = 68
);
    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ-1:0][15:0]       req_len;
    logic [NUM_REQ-1:0]             wr_valid;
    logic [NUM_REQ-1:0][15:0]       wr_data;
    logic [NUM_REQ-1:0]             gnt;
    logic [NUM_REQ-1:0]             done;
    logic [NUM_REQ-1:0]             err;
    logic [MAX_WORDS-1:0][15:0]     packet;
    logic [15:0]                    packet_length;
    logic                           clear_to_send;
    logic                           tx_ack;
    logic                           tx_done;
    logic                           busy;

    modport master (
        output req, req_len, wr_valid, wr_data, tx_ack, tx_done,
        input  gnt, done, err, packet, packet_length, clear_to_send, busy
    );

    modport slave (
        input  req, req_len, wr_valid, wr_data, tx_ack, tx_done,
        output gnt, done, err, packet, packet_length, clear_to_send, busy
    );
endinterface

// File: rtl/enet_tx_arbiter.sv
// Round-robin scheduler sharing the DM9000A transmit path: grant, stage words
// into the packet buffer, hand it to the driver, wait for completion or timeout.
module enet_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int MAX_WORDS      = 68,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic             clk100,
    input  logic             rst_n,
    enet_tx_arbiter_if.slave bus
);
    localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WPW = $clog2(MAX_WORDS);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, FILL, SEND, WAIT_DONE} state_t;

    state_t                     state_q, state_d;
    logic [IW-1:0]              rr_q, rr_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic [15:0]                len_q, len_d;
    logic [WPW-1:0]             wp_q, wp_d;
    logic [TW-1:0]              tmo_q, tmo_d;
    logic [NUM_REQ-1:0]         gnt_q, gnt_d;
    logic [NUM_REQ-1:0]         done_q, done_d;
    logic [NUM_REQ-1:0]         err_q, err_d;
    logic                       cts_q, cts_d;
    logic                       busy_q, busy_d;
    logic [15:0]                plen_q, plen_d;
    logic [MAX_WORDS-1:0][15:0] packet_q, packet_d;

    logic          found;
    logic [IW-1:0] sel;
    logic [IW-1:0] cand;

    function automatic logic [IW-1:0] rr_after(input logic [IW-1:0] i);
        rr_after = (int'(i) == NUM_REQ - 1) ? '0 : IW'(int'(i) + 1);
    endfunction

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        idx_d    = idx_q;
        len_d    = len_q;
        wp_d     = wp_q;
        tmo_d    = tmo_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        err_d    = '0;
        cts_d    = cts_q;
        plen_d   = plen_q;
        packet_d = packet_q;
        found    = 1'b0;
        sel      = '0;
        cand     = '0;

        // First requesting source at or after the round-robin pointer.
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IW'((int'(rr_q) + k) % NUM_REQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    idx_d = sel;
                    len_d = bus.req_len[sel];
                    if (bus.req_len[sel] == 16'd0 || bus.req_len[sel] > 16'(MAX_WORDS)) begin
                        err_d[sel] = 1'b1;
                        rr_d       = rr_after(sel);
                    end else begin
                        gnt_d      = '0;
                        gnt_d[sel] = 1'b1;
                        wp_d       = '0;
                        state_d    = FILL;
                    end
                end
            end
            FILL: begin
                // A dropped request wins over a word strobed in the same cycle.
                if (!bus.req[idx_q]) begin
                    gnt_d        = '0;
                    err_d[idx_q] = 1'b1;
                    rr_d         = rr_after(idx_q);
                    state_d      = IDLE;
                end else if (bus.wr_valid[idx_q]) begin
                    packet_d[wp_q] = bus.wr_data[idx_q];
                    if (16'(wp_q) + 16'd1 == len_q) begin
                        plen_d  = len_q;
                        cts_d   = 1'b1;
                        tmo_d   = '0;
                        state_d = SEND;
                    end else begin
                        wp_d = wp_q + WPW'(1);
                    end
                end
            end
            SEND, WAIT_DONE: begin
                if (bus.tx_done) begin
                    done_d[idx_q] = 1'b1;
                    gnt_d         = '0;
                    cts_d         = 1'b0;
                    rr_d          = rr_after(idx_q);
                    state_d       = IDLE;
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_d[idx_q] = 1'b1;
                    gnt_d        = '0;
                    cts_d        = 1'b0;
                    rr_d         = rr_after(idx_q);
                    state_d      = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                    if (state_q == SEND && bus.tx_ack) begin
                        cts_d   = 1'b0;
                        state_d = WAIT_DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_q     <= '0;
            idx_q    <= '0;
            len_q    <= '0;
            wp_q     <= '0;
            tmo_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            err_q    <= '0;
            cts_q    <= 1'b0;
            busy_q   <= 1'b0;
            plen_q   <= '0;
            packet_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            wp_q     <= wp_d;
            tmo_q    <= tmo_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            cts_q    <= cts_d;
            busy_q   <= busy_d;
            plen_q   <= plen_d;
            packet_q <= packet_d;
        end
    end

    assign bus.gnt           = gnt_q;
    assign bus.done          = done_q;
    assign bus.err           = err_q;
    assign bus.clear_to_send = cts_q;
    assign bus.busy          = busy_q;
    assign bus.packet_length = plen_q;
    assign bus.packet        = packet_q;
endmodule

// File: tb/tb_enet_tx_arbiter.sv
// Bench for enet_tx_arbiter: a transaction-level model is compared against the
// DUT every cycle, plus directed scenarios with hand-computed literal results.
module tb_enet_tx_arbiter;
    localparam int NR  = 4;
    localparam int MW  = 68;
    localparam int TMO = 100;

    logic clk100 = 1'b0;
    logic rst_n  = 1'b0;

    enet_tx_arbiter_if #(.NUM_REQ(NR), .MAX_WORDS(MW)) bus();

    enet_tx_arbiter #(.NUM_REQ(NR), .MAX_WORDS(MW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk100 (clk100),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    initial forever #5 clk100 = ~clk100;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: who owns the path, how many words are still due, when the
    // buffer was handed over, and the outputs the DUT must show.
    int          m_owner = -1, m_rr = 0, m_need = 0, m_got = 0, t_send = 0, cyc = 0;
    logic [3:0]  e_gnt = '0, e_done = '0, e_err = '0;
    logic        e_cts = 1'b0, e_busy = 1'b0;
    logic [15:0] e_plen = '0;
    logic [15:0] e_pkt [MW];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic release_owner();
        e_gnt   = '0;
        e_cts   = 1'b0;
        m_rr    = (m_owner + 1) % NR;
        m_owner = -1;
    endtask

    task automatic model_step();
        logic [1:0] c;
        bit         hit;
        int         len;
        c   = '0;
        hit = 1'b0;
        if (!rst_n) begin
            m_owner = -1; m_rr = 0; m_need = 0; m_got = 0;
            e_gnt = '0; e_done = '0; e_err = '0; e_cts = 1'b0; e_busy = 1'b0; e_plen = '0;
            for (int i = 0; i < MW; i++) e_pkt[i] = '0;
            return;
        end
        cyc++;
        e_done = '0;
        e_err  = '0;
        if (m_owner < 0) begin
            for (int k = 0; k < NR; k++) begin
                if (!hit && bus.req[2'((m_rr + k) % NR)]) begin
                    hit = 1'b1;
                    c   = 2'((m_rr + k) % NR);
                end
            end
            if (hit) begin
                len = int'(bus.req_len[c]);
                if (len == 0 || len > MW) begin
                    e_err[c] = 1'b1;
                    m_rr     = (int'(c) + 1) % NR;
                end else begin
                    m_owner  = int'(c);
                    m_need   = len;
                    m_got    = 0;
                    e_gnt[c] = 1'b1;
                end
            end
        end else if (m_got < m_need) begin
            c = 2'(m_owner);
            if (!bus.req[c]) begin
                e_err[c] = 1'b1;
                release_owner();
            end else if (bus.wr_valid[c]) begin
                e_pkt[m_got] = bus.wr_data[c];
                m_got++;
                if (m_got == m_need) begin
                    e_cts  = 1'b1;
                    e_plen = 16'(m_need);
                    t_send = cyc;
                end
            end
        end else begin
            c = 2'(m_owner);
            if (bus.tx_done) begin
                e_done[c] = 1'b1;
                release_owner();
            end else if (cyc - t_send == TMO) begin
                e_err[c] = 1'b1;
                release_owner();
            end else if (bus.tx_ack) begin
                e_cts = 1'b0;
            end
        end
        e_busy = (m_owner >= 0);
    endtask

    initial forever begin
        @(posedge clk100 or negedge rst_n);
        model_step();
    end

    task automatic compare_all();
        int bad;
        bad = -1;
        chk("gnt", 32'(bus.gnt), 32'(e_gnt));
        chk("done", 32'(bus.done), 32'(e_done));
        chk("err", 32'(bus.err), 32'(e_err));
        chk("cts", 32'(bus.clear_to_send), 32'(e_cts));
        chk("busy", 32'(bus.busy), 32'(e_busy));
        chk("plen", 32'(bus.packet_length), 32'(e_plen));
        chk("onehot", 32'($countones(bus.gnt) <= 1), 32'd1);
        for (int i = 0; i < MW; i++)
            if (bad < 0 && bus.packet[i] !== e_pkt[i]) bad = i;
        chk("packet_first_bad_word", 32'(bad), 32'hffff_ffff);
    endtask

    initial forever begin
        @(negedge clk100);
        compare_all();
    end

    task automatic wait_gnt(output int idx);
        int n;
        idx = -1;
        n   = 0;
        do begin
            @(negedge clk100);
            n++;
        end while (bus.gnt == '0 && n < 30);
        for (int i = 0; i < NR; i++) if (bus.gnt[i]) idx = i;
        chk("gnt_wait", 32'(bus.gnt != '0), 32'd1);
    endtask

    task automatic send_words(input logic [1:0] i, input int n, input logic [15:0] base,
                              input logic [15:0] step);
        for (int w = 0; w < n; w++) begin
            bus.wr_valid[i] = 1'b1;
            bus.wr_data[i]  = base + 16'(w) * step;
            @(negedge clk100);
        end
        bus.wr_valid[i] = 1'b0;
    endtask

    task automatic wait_cts();
        int n;
        n = 0;
        while (!bus.clear_to_send && n < 20) begin
            @(negedge clk100);
            n++;
        end
        chk("cts_wait", 32'(bus.clear_to_send), 32'd1);
    endtask

    task automatic finish_tx(input bit same);
        if (same) begin
            bus.tx_ack  = 1'b1;
            bus.tx_done = 1'b1;
            @(negedge clk100);
            bus.tx_ack  = 1'b0;
            bus.tx_done = 1'b0;
        end else begin
            bus.tx_ack = 1'b1;
            @(negedge clk100);
            bus.tx_ack = 1'b0;
            chk("ack_drops_cts", 32'(bus.clear_to_send), 32'd0);
            repeat (2) @(negedge clk100);
            bus.tx_done = 1'b1;
            @(negedge clk100);
            bus.tx_done = 1'b0;
        end
    endtask

    task automatic serve(input int n_words, input logic [15:0] base, output int idx);
        wait_gnt(idx);
        if (idx < 0) return;
        send_words(2'(idx), n_words, base, 16'd1);
        wait_cts();
        finish_tx(1'b0);
    endtask

    int idx;
    int n;
    int order [$];
    int exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        bus.req = '0; bus.req_len = '0; bus.wr_valid = '0; bus.wr_data = '0;
        bus.tx_ack = 1'b0; bus.tx_done = 1'b0;

        // Reset values
        repeat (3) @(negedge clk100);
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_cts", 32'(bus.clear_to_send), 32'd0);
        chk("rst_plen", 32'(bus.packet_length), 32'd0);
        chk("rst_pkt0", 32'(bus.packet[0]), 32'd0);
        rst_n = 1'b1;

        // Single requester 0, four words
        bus.req_len[0] = 16'd4;
        bus.req[0]     = 1'b1;
        @(negedge clk100);
        chk("t1_gnt_latency", 32'(bus.gnt), 32'h1);
        send_words(2'd0, 4, 16'h1111, 16'h1111);
        chk("t1_cts_after_last", 32'(bus.clear_to_send), 32'd1);
        chk("t1_plen", 32'(bus.packet_length), 32'd4);
        chk("t1_pkt0", 32'(bus.packet[0]), 32'h1111);
        chk("t1_pkt1", 32'(bus.packet[1]), 32'h2222);
        chk("t1_pkt2", 32'(bus.packet[2]), 32'h3333);
        chk("t1_pkt3", 32'(bus.packet[3]), 32'h4444);
        bus.req[0] = 1'b0;
        repeat (2) @(negedge clk100);
        finish_tx(1'b0);
        chk("t1_done", 32'(bus.done), 32'h1);
        chk("t1_gnt_off", 32'(bus.gnt), 32'd0);
        @(negedge clk100);
        chk("t1_done_pulse", 32'(bus.done), 32'd0);

        rst_n = 1'b0;
        @(negedge clk100);
        rst_n = 1'b1;

        // All four requesting: round-robin order 0,1,2,3,0
        for (int i = 0; i < NR; i++) bus.req_len[i] = 16'd2;
        bus.req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            serve(2, 16'(16'h0100 * (g + 1)), idx);
            order.push_back(idx);
        end
        bus.req = '0;
        for (int k = 0; k < 5; k++)
            chk("t2_order", 32'(k < order.size() ? order[k] : -1), 32'(exp_order[k]));

        // Bad lengths: requester 2 len 0, requester 3 len 69
        bus.req_len[2] = 16'd0;
        bus.req_len[3] = 16'd69;
        bus.req        = 4'b1100;
        @(negedge clk100);
        chk("t3_err2", 32'(bus.err), 32'h4);
        chk("t3_nogrant", 32'(bus.gnt), 32'd0);
        @(negedge clk100);
        chk("t3_err3", 32'(bus.err), 32'h8);
        chk("t3_nocts", 32'(bus.clear_to_send), 32'd0);
        bus.req = '0;
        @(negedge clk100);
        chk("t3_err_quiet", 32'(bus.err), 32'd0);

        // Requester 1 abandons after 3 of 10 words; requester 2 follows
        bus.req_len[1] = 16'd10;
        bus.req_len[2] = 16'd2;
        bus.req        = 4'b0110;
        wait_gnt(idx);
        chk("t4_first_gnt", 32'(idx), 32'd1);
        send_words(2'd1, 3, 16'hA000, 16'd1);
        bus.req[1] = 1'b0;
        @(negedge clk100);
        chk("t4_abort_err", 32'(bus.err), 32'h2);
        chk("t4_abort_gnt", 32'(bus.gnt), 32'd0);
        wait_gnt(idx);
        chk("t4_next_gnt", 32'(idx), 32'd2);
        send_words(2'd2, 2, 16'hB000, 16'd1);
        wait_cts();
        bus.req = '0;
        finish_tx(1'b0);

        // Timeout: ack but never done
        bus.req_len[3] = 16'd1;
        bus.req        = 4'b1000;
        wait_gnt(idx);
        chk("t5_gnt", 32'(idx), 32'd3);
        send_words(2'd3, 1, 16'hBEEF, 16'd0);
        chk("t5_cts", 32'(bus.clear_to_send), 32'd1);
        bus.req    = '0;
        bus.tx_ack = 1'b1;
        n = 0;
        do begin
            @(negedge clk100);
            n++;
            bus.tx_ack = 1'b0;
        end while (!bus.err[3] && n < 200);
        chk("t5_tmo_cycles", 32'(n), 32'd100);
        chk("t5_tmo_err", 32'(bus.err), 32'h8);
        chk("t5_tmo_nodone", 32'(bus.done), 32'd0);

        // tx_ack and tx_done together -> done only
        bus.req_len[0] = 16'd1;
        bus.req        = 4'b0001;
        wait_gnt(idx);
        send_words(2'd0, 1, 16'hC0DE, 16'd0);
        wait_cts();
        bus.req = '0;
        finish_tx(1'b1);
        chk("t5_same_done", 32'(bus.done), 32'h1);
        chk("t5_same_noerr", 32'(bus.err), 32'd0);

        // Asynchronous reset while waiting for tx_done
        bus.req_len[1] = 16'd1;
        bus.req        = 4'b0010;
        wait_gnt(idx);
        send_words(2'd1, 1, 16'hD00D, 16'd0);
        wait_cts();
        bus.req    = '0;
        bus.tx_ack = 1'b1;
        @(negedge clk100);
        bus.tx_ack = 1'b0;
        @(negedge clk100);
        chk("t6_busy_before", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_gnt", 32'(bus.gnt), 32'd0);
        chk("t6_async_busy", 32'(bus.busy), 32'd0);
        chk("t6_async_plen", 32'(bus.packet_length), 32'd0);
        chk("t6_async_pkt0", 32'(bus.packet[0]), 32'd0);
        chk("t6_async_pulses", 32'({bus.done, bus.err}), 32'd0);
        @(negedge clk100);
        rst_n = 1'b1;
        for (int i = 0; i < NR; i++) bus.req_len[i] = 16'd1;
        bus.req = 4'b1111;
        wait_gnt(idx);
        chk("t6_restart_at_0", 32'(idx), 32'd0);
        send_words(2'd0, 1, 16'hE000, 16'd0);
        wait_cts();
        bus.req = '0;
        finish_tx(1'b1);
        repeat (3) @(negedge clk100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1);
    end
endmodule

// File: doc/enet_tx_arbiter.md
# enet_tx_arbiter

Round-robin transmit scheduler that shares the single DM9000A transmit path between `NUM_REQ` packet sources. It grants one requester at a time, stages its packet words into a 68-word buffer, presents the buffer to the DM9000A driver with `clear_to_send`/`packet_length`, and waits for completion before serving the next requester. It sits between the protocol/packet generators and the DM9000A chip interface block.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `MAX_WORDS`, 68: staging buffer depth in 16-bit words; must match the driver's packet array.
- `TIMEOUT_CYCLES`, 2000000: clk100 cycles allowed from `clear_to_send` assertion to `tx_done` (20 ms).

Ports:
- `clk100`  in  1  system clock, 100 MHz; only clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  NUM_REQ  per-requester transmit request, level.
- `req_len`  in  NUM_REQ x 16  packet length in words, sampled at grant.
- `wr_valid`  in  NUM_REQ  per-requester word strobe.
- `wr_data`  in  NUM_REQ x 16  per-requester word.
- `gnt`  out  NUM_REQ  one-hot grant; at most one bit high.
- `done`  out  NUM_REQ  one-cycle pulse: packet transmitted.
- `err`  out  NUM_REQ  one-cycle pulse: rejected length, abort or timeout.
- `packet`  out  MAX_WORDS x 16  staging buffer to driver.
- `packet_length`  out  16  word count to driver.
- `clear_to_send`  out  1  buffer valid, driver may start.
- `tx_ack`  in  1  driver pulse: copy into DM9000A SRAM started.
- `tx_done`  in  1  driver pulse: TX complete interrupt observed.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, FILL, SEND, WAIT_DONE.
- IDLE: if any `req` bit set, select the first set bit at or after round-robin pointer `rr` (wrapping NUM_REQ-1 -> 0); latch index and `req_len`; check length.
  - Length 0 or > MAX_WORDS: pulse `err[i]` next cycle, no grant, `rr` <= i+1, stay IDLE.
  - Otherwise: `gnt[i]`=1, word pointer `wp`=0, -> FILL.
- FILL: each cycle with `wr_valid[i]`, `packet[wp]` <= `wr_data[i]`, `wp`++; other requesters' strobes ignored. When `wp` reaches latched length -> SEND, `packet_length` <= length, `clear_to_send`=1.
  - `req[i]` falls during FILL: abort; `gnt`=0, pulse `err[i]`, `rr` <= i+1, -> IDLE, `clear_to_send` never asserted.
- SEND: hold `clear_to_send`=1 until `tx_ack`; then `clear_to_send`=0, -> WAIT_DONE.
- WAIT_DONE: on `tx_done`: pulse `done[i]`, `gnt`=0, `rr` <= i+1, -> IDLE.
- `tx_done` in SEND (with or without `tx_ack`): treated as completion, same as WAIT_DONE.
- Timeout: counter cleared on entry to SEND, counts in SEND and WAIT_DONE; at TIMEOUT_CYCLES: `clear_to_send`=0, pulse `err[i]`, `gnt`=0, `rr` <= i+1, -> IDLE.
- `packet`, `packet_length` unchanged from SEND entry until the next FILL; `req` changes after FILL are ignored until IDLE.
- Wrap-around: `rr` increments modulo NUM_REQ.

## Timing
- Reset (async assert, sync release): state IDLE, `rr`=0, `gnt`=0, `done`=0, `err`=0, `clear_to_send`=0, `busy`=0, `packet_length`=0, `packet` all 0, timeout counter 0.
- Reset mid-operation: all of the above immediately; no `done`/`err` pulse.
- Grant latency: `req` high in cycle N (IDLE) -> `gnt` high in N+1.
- Word accepted in the cycle `wr_valid[i]` is high while `gnt[i]` high; last word in cycle M -> `clear_to_send` high in M+1.
- `tx_ack` in cycle K -> `clear_to_send` low in K+1.
- `tx_done` in cycle D -> `done[i]` high exactly in D+1, `gnt` low in D+1, new grant earliest D+2.
- All outputs registered.

## Test plan
- Single requester 0, len 4, words 0x1111..0x4444 back-to-back -> `packet[0..3]` match, `packet_length`=4, `clear_to_send` 1 cycle after last word, `done[0]` 1 cycle after `tx_done`.
- `req`=4'b1111 held, each len 2 -> grants in order 0,1,2,3,0; exactly one `gnt` bit ever high.
- Requester 2 len 0 and requester 3 len 69 -> `err[2]`, `err[3]` pulses, no `clear_to_send`, `rr` advances past each.
- Requester 1 drops `req` after 3 of 10 words -> `err[1]`, return to IDLE, requester 2 granted next.
- No `tx_done` after `tx_ack` (TIMEOUT_CYCLES=100) -> `err[i]` at cycle 100 after SEND entry; `tx_ack`+`tx_done` same cycle -> `done[i]` only.
- `rst_n` low during WAIT_DONE -> all outputs reset values asynchronously, next grant starts at requester 0.
